// File: rtl/int_sequencer_if.sv
// Signal bundle between a core's interrupt front end and int_sequencer.
// The master side drives the request/pipeline inputs; the slave side is the sequencer.
interface int_sequencer_if;
  logic [3:0]  intCode;
  logic        intEn;
  logic        glbEn;
  logic        pipeEmpty;
  logic [15:0] nextPC;
  logic        rti;
  logic        stall;
  logic        jumpEn;
  logic [15:0] jumpAddr;
  logic        intAck;
  logic [3:0]  ackCode;
  logic        inIsr;
  logic [15:0] epc;

  modport master (
    output intCode, intEn, glbEn, pipeEmpty, nextPC, rti,
    input  stall, jumpEn, jumpAddr, intAck, ackCode, inIsr, epc
  );

  modport slave (
    input  intCode, intEn, glbEn, pipeEmpty, nextPC, rti,
    output stall, jumpEn, jumpAddr, intAck, ackCode, inIsr, epc
  );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: drains the pipeline, jumps to the code's vector,
// saves the return PC and jumps back on return-from-interrupt.
module int_sequencer #(
  parameter logic [15:0] VEC_BASE  = 16'h0010,
  parameter int          VEC_SHIFT = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [3:0]  i_intCode,
  input  logic        i_intEn,
  input  logic        i_glbEn,
  input  logic        i_pipeEmpty,
  input  logic [15:0] i_nextPC,
  input  logic        i_rti,
  output logic        o_stall,
  output logic        o_jumpEn,
  output logic [15:0] o_jumpAddr,
  output logic        o_intAck,
  output logic [3:0]  o_ackCode,
  output logic        o_inIsr,
  output logic [15:0] o_epc
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_ENTER = 3'd2,
    S_ISR   = 3'd3,
    S_EXIT  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] epc_q, epc_d;
  logic        req;
  logic [15:0] vec_addr;

  assign req      = i_intEn & i_glbEn;
  // Vector address comes from the registered code only, so i_intCode never reaches an output.
  assign vec_addr = VEC_BASE + ({12'h000, code_q} << VEC_SHIFT);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      code_q  <= 4'h0;
      epc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    epc_d      = epc_q;
    o_stall    = 1'b0;
    o_jumpEn   = 1'b0;
    o_jumpAddr = 16'h0000;
    o_intAck   = 1'b0;
    o_inIsr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        o_stall = 1'b1;
        // A withdrawn request wins over a drained pipeline.
        if (!req) begin
          state_d = S_IDLE;
        end else if (i_pipeEmpty) begin
          code_d  = i_intCode;
          epc_d   = i_nextPC;
          state_d = S_ENTER;
        end
      end
      S_ENTER: begin
        o_stall    = 1'b1;
        o_jumpEn   = 1'b1;
        o_intAck   = 1'b1;
        o_jumpAddr = vec_addr;
        state_d    = S_ISR;
      end
      S_ISR: begin
        o_inIsr = 1'b1;
        if (i_rti) state_d = S_EXIT;
      end
      S_EXIT: begin
        o_jumpEn   = 1'b1;
        o_jumpAddr = epc_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ackCode = code_q;
  assign o_epc     = epc_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed entry/return/preempt/abort/mask/reset
// scenarios plus randomized transactions checked against a transaction-level model.
module tb_int_sequencer;

  localparam logic [15:0] VB = 16'h0010;
  localparam int          VS = 2;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  // Model of architectural state: last serviced code/epc and expected jump targets.
  logic [3:0]  m_code;
  logic [15:0] m_epc;
  logic [15:0] exp_q[$];

  int_sequencer_if bus();

  int_sequencer #(.VEC_BASE(VB), .VEC_SHIFT(VS)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_intCode   (bus.intCode),
    .i_intEn     (bus.intEn),
    .i_glbEn     (bus.glbEn),
    .i_pipeEmpty (bus.pipeEmpty),
    .i_nextPC    (bus.nextPC),
    .i_rti       (bus.rti),
    .o_stall     (bus.stall),
    .o_jumpEn    (bus.jumpEn),
    .o_jumpAddr  (bus.jumpAddr),
    .o_intAck    (bus.intAck),
    .o_ackCode   (bus.ackCode),
    .o_inIsr     (bus.inIsr),
    .o_epc       (bus.epc)
  );

  logic [39:0] obs;
  assign obs = {bus.stall, bus.jumpEn, bus.jumpAddr, bus.intAck, bus.inIsr, bus.ackCode, bus.epc};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pack(input logic s, input logic j, input logic [15:0] a,
                                       input logic k, input logic isr,
                                       input logic [3:0] c, input logic [15:0] e);
    return {s, j, a, k, isr, c, e};
  endfunction

  function automatic logic [15:0] vector_of(input logic [3:0] c);
    int t;
    t = (int'(VB) + int'(c) * (1 << VS)) % 65536;
    return t[15:0];
  endfunction

  function automatic logic [3:0] rnd_code();
    return 4'($urandom_range(1, 15));
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.intEn     = 1'b0;
    bus.glbEn     = 1'b1;
    bus.intCode   = 4'h0;
    bus.pipeEmpty = 1'b0;
    bus.nextPC    = 16'h0000;
    bus.rti       = 1'b0;
  endtask

  // Full entry/return transaction. c0 is the code when the request is first seen,
  // c1 the code presented during the drain and at the drained edge.
  task automatic run_irq(input logic [3:0] c0, input logic [3:0] c1, input logic [15:0] pc,
                         input int drain_len, input int isr_len, input bit hold);
    logic [39:0] exp;
    bus.glbEn = 1'b1; bus.intEn = 1'b1; bus.intCode = c0;
    bus.pipeEmpty = 1'b0; bus.rti = 1'b0; bus.nextPC = 16'($urandom);
    tick();
    exp = pack(1, 0, 16'h0000, 0, 0, m_code, m_epc);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL drain_entry obs=%h exp=%h", obs, exp); end
    for (int k = 0; k < drain_len; k++) begin
      bus.intCode = c1; bus.pipeEmpty = 1'b0; bus.nextPC = 16'($urandom);
      tick();
      exp = pack(1, 0, 16'h0000, 0, 0, m_code, m_epc);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL drain_hold obs=%h exp=%h", obs, exp); end
    end
    bus.intCode = c1; bus.pipeEmpty = 1'b1; bus.nextPC = pc;
    tick();
    m_code = c1;
    m_epc  = pc;
    exp_q.push_back(vector_of(c1));
    exp = pack(1, 1, exp_q.pop_front(), 1, 0, m_code, m_epc);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL enter obs=%h exp=%h", obs, exp); end
    bus.pipeEmpty = 1'($urandom); bus.nextPC = 16'($urandom);
    bus.intEn = hold; bus.intCode = rnd_code();
    tick();
    exp = pack(0, 0, 16'h0000, 0, 1, m_code, m_epc);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL isr_first obs=%h exp=%h", obs, exp); end
    for (int k = 0; k < isr_len; k++) begin
      bus.intCode = rnd_code(); bus.nextPC = 16'($urandom); bus.pipeEmpty = 1'($urandom);
      tick();
      exp = pack(0, 0, 16'h0000, 0, 1, m_code, m_epc);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL isr_hold obs=%h exp=%h", obs, exp); end
    end
    bus.rti = 1'b1;
    tick();
    exp_q.push_back(m_epc);
    exp = pack(0, 1, exp_q.pop_front(), 0, 0, m_code, m_epc);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL exit obs=%h exp=%h", obs, exp); end
    bus.rti = 1'b0;
    tick();
    exp = pack(0, 0, 16'h0000, 0, 0, m_code, m_epc);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL post_exit_idle obs=%h exp=%h", obs, exp); end
    if (hold) begin
      tick();
      exp = pack(1, 0, 16'h0000, 0, 0, m_code, m_epc);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reentry_drain obs=%h exp=%h", obs, exp); end
      bus.intEn = 1'b0;
      tick();
      exp = pack(0, 0, 16'h0000, 0, 0, m_code, m_epc);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reentry_abort obs=%h exp=%h", obs, exp); end
    end
    idle_inputs();
  endtask

  // Request withdrawn during the drain, with the pipeline reporting drained at the same edge.
  task automatic run_abort(input logic [3:0] c, input int drain_len, input bit drop_glb);
    logic [39:0] exp;
    bus.glbEn = 1'b1; bus.intEn = 1'b1; bus.intCode = c; bus.pipeEmpty = 1'b0;
    tick();
    exp = pack(1, 0, 16'h0000, 0, 0, m_code, m_epc);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_drain obs=%h exp=%h", obs, exp); end
    for (int k = 0; k < drain_len; k++) tick();
    if (drop_glb) bus.glbEn = 1'b0; else bus.intEn = 1'b0;
    bus.pipeEmpty = 1'b1; bus.nextPC = 16'($urandom);
    tick();
    exp = pack(0, 0, 16'h0000, 0, 0, m_code, m_epc);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_idle obs=%h exp=%h", obs, exp); end
    idle_inputs();
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_settle obs=%h exp=%h", obs, exp); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #2;
    checks++;
    if (obs !== 40'h0) begin errors++; $display("FAIL reset_outputs obs=%h exp=%h", obs, 40'h0); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++;
    if (obs !== 40'h0) begin errors++; $display("FAIL reset_release obs=%h exp=%h", obs, 40'h0); end
  endtask

  task automatic test_entry_return();
    // Drained on the third stall cycle: DRAIN, DRAIN, DRAIN(pipeEmpty) -> ENTER.
    run_irq(4'h5, 4'h5, 16'h0123, 2, 2, 1'b0);
    checks++;
    if (bus.epc !== 16'h0123 || vector_of(4'h5) !== 16'h0024) begin
      errors++; $display("FAIL entry_epc obs=%h exp=%h", bus.epc, 16'h0123);
    end
  endtask

  task automatic test_preempt();
    run_irq(4'h3, 4'hB, 16'h0456, 1, 1, 1'b0);
    checks++;
    if (bus.ackCode !== 4'hB) begin
      errors++; $display("FAIL preempt_code obs=%h exp=%h", bus.ackCode, 4'hB);
    end
  endtask

  task automatic test_abort();
    run_abort(4'h7, 2, 1'b0);
    run_abort(4'h2, 0, 1'b1);
  endtask

  task automatic test_masking();
    logic [39:0] exp;
    bus.glbEn = 1'b0; bus.intEn = 1'b1; bus.intCode = 4'h9; bus.pipeEmpty = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.rti = 1'($urandom);
      tick();
      exp = pack(0, 0, 16'h0000, 0, 0, m_code, m_epc);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL masked_idle obs=%h exp=%h", obs, exp); end
    end
    idle_inputs();
    run_irq(4'hE, 4'hE, 16'hBEEF, 0, 3, 1'b1);
  endtask

  // Reset asserted mid-operation: where 0=DRAIN 1=ENTER 2=ISR 3=EXIT.
  task automatic test_reset_midop(input int where);
    logic [39:0] exp;
    bus.glbEn = 1'b1; bus.intEn = 1'b1; bus.intCode = 4'h6; bus.pipeEmpty = 1'b0;
    tick();
    if (where >= 1) begin
      bus.pipeEmpty = 1'b1; bus.nextPC = 16'h0ABC;
      tick();
    end
    if (where >= 2) begin
      bus.intEn = 1'b0; bus.pipeEmpty = 1'b0;
      tick();
      m_code = 4'h6; m_epc = 16'h0ABC;
      exp = pack(0, 0, 16'h0000, 0, 1, m_code, m_epc);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL pre_reset_isr obs=%h exp=%h", obs, exp); end
    end
    if (where >= 3) begin
      bus.rti = 1'b1;
      tick();
    end
    #2;
    rstn = 1'b0;
    #1;
    m_code = 4'h0; m_epc = 16'h0000;
    checks++;
    if (obs !== 40'h0) begin errors++; $display("FAIL reset_async_%0d obs=%h exp=%h", where, obs, 40'h0); end
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    bus.rti = 1'b1;
    tick();
    checks++;
    if (obs !== 40'h0) begin errors++; $display("FAIL rti_after_reset obs=%h exp=%h", obs, 40'h0); end
    bus.rti = 1'b0;
    tick();
    checks++;
    if (obs !== 40'h0) begin errors++; $display("FAIL idle_after_reset obs=%h exp=%h", obs, 40'h0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0: run_irq(rnd_code(), rnd_code(), 16'($urandom), $urandom_range(0, 4),
                   $urandom_range(0, 4), 1'($urandom));
        1: run_abort(rnd_code(), $urandom_range(0, 3), 1'($urandom));
        default: begin
          bus.glbEn = 1'b0; bus.intEn = 1'b1; bus.intCode = rnd_code();
          tick();
          checks++;
          if (obs !== pack(0, 0, 16'h0000, 0, 0, m_code, m_epc)) begin
            errors++; $display("FAIL rand_masked obs=%h", obs);
          end
          idle_inputs();
        end
      endcase
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    m_code = 4'h0;
    m_epc  = 16'h0000;
    test_reset();
    test_entry_return();
    test_preempt();
    test_abort();
    test_masking();
    for (int w = 0; w < 4; w++) test_reset_midop(w);
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain obs=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
